// File: rtl/control_unit.sv
// Fetch/execute controller of the accumulator CPU: holds PC and IR, decodes
// opcodes into datapath controls and resolves Z/N branches.
module control_unit #(
    parameter int unsigned DATA_WIDTH   = 11,
    parameter int unsigned OPCODE_WIDTH = 5,
    parameter int unsigned ADDR_WIDTH   = 11
) (
    input  logic                               clock_in,
    input  logic                               reset_in,
    input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instruction_in,
    input  logic                               flag_Z_in,
    input  logic                               flag_N_in,
    output logic [ADDR_WIDTH-1:0]              program_address_out,
    output logic [DATA_WIDTH-1:0]              operand_out,
    output logic                               alu_op_out,
    output logic [1:0]                         sel_A_out,
    output logic                               sel_B_out,
    output logic                               acc_wr_out,
    output logic                               acc_reset_out,
    output logic                               status_wr_out,
    output logic                               status_reset_out,
    output logic                               data_memory_wr_out,
    output logic                               halted_out
);

    localparam int unsigned INSTR_WIDTH = OPCODE_WIDTH + DATA_WIDTH;

    localparam logic [1:0] S_FETCH   = 2'b00;
    localparam logic [1:0] S_EXECUTE = 2'b01;
    localparam logic [1:0] S_HALT    = 2'b10;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(12);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(13);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(14);

    logic [1:0]              state, state_next;
    logic [ADDR_WIDTH-1:0]   pc, pc_next;
    logic [INSTR_WIDTH-1:0]  ir, ir_next;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0]   operand;
    logic [ADDR_WIDTH-1:0]   branch_target;
    logic                    taken;

    assign opcode        = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign operand       = ir[DATA_WIDTH-1:0];
    assign branch_target = ADDR_WIDTH'(operand);

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // Next-state, PC update and EXECUTE-cycle decode; strobes are driven from IR only in EXECUTE.
    always_comb begin
        state_next         = state;
        pc_next            = pc;
        ir_next            = ir;
        taken              = 1'b0;
        alu_op_out         = 1'b0;
        sel_A_out          = 2'b00;
        sel_B_out          = 1'b0;
        acc_wr_out         = 1'b0;
        status_wr_out      = 1'b0;
        data_memory_wr_out = 1'b0;
        case (state)
            S_FETCH: begin
                ir_next    = instruction_in;
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_next = S_FETCH;
                case (opcode)
                    OP_HLT:  state_next = S_HALT;
                    OP_STO:  data_memory_wr_out = 1'b1;
                    OP_LD: begin
                        sel_A_out  = 2'b01;
                        acc_wr_out = 1'b1;
                    end
                    OP_LDI: begin
                        sel_A_out  = 2'b10;
                        acc_wr_out = 1'b1;
                    end
                    OP_ADD:  acc_wr_out = 1'b1;
                    OP_ADDI: begin
                        sel_B_out  = 1'b1;
                        acc_wr_out = 1'b1;
                    end
                    OP_SUB: begin
                        alu_op_out    = 1'b1;
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                    end
                    OP_SUBI: begin
                        sel_B_out     = 1'b1;
                        alu_op_out    = 1'b1;
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                    end
                    OP_BEQ:  taken = flag_Z_in;
                    OP_BNE:  taken = !flag_Z_in;
                    OP_BGT:  taken = !flag_Z_in && !flag_N_in;
                    OP_BGE:  taken = !flag_N_in;
                    OP_BLT:  taken = flag_N_in;
                    OP_BLE:  taken = flag_N_in || flag_Z_in;
                    OP_JMP:  taken = 1'b1;
                    default: ;
                endcase
                if (opcode == OP_HLT) begin
                    pc_next = pc;
                end else if (taken) begin
                    pc_next = branch_target;
                end else begin
                    pc_next = pc + ADDR_WIDTH'(1);
                end
            end
            S_HALT: ;
            default: state_next = S_FETCH;
        endcase
    end

    assign program_address_out = pc;
    assign operand_out         = operand;
    assign halted_out          = (state == S_HALT);
    assign acc_reset_out       = reset_in;
    assign status_reset_out    = reset_in;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level reference model predicts
// every cycle's outputs; directed probes pin the documented scenarios to constants.
module tb_control_unit;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic [15:0] instruction_in;
    logic        flag_Z_in = 1'b0;
    logic        flag_N_in = 1'b0;
    logic [10:0] program_address_out;
    logic [10:0] operand_out;
    logic        alu_op_out;
    logic [1:0]  sel_A_out;
    logic        sel_B_out;
    logic        acc_wr_out;
    logic        acc_reset_out;
    logic        status_wr_out;
    logic        status_reset_out;
    logic        data_memory_wr_out;
    logic        halted_out;

    logic [15:0] mem [0:2047];

    assign instruction_in = mem[program_address_out];

    control_unit dut (
        .clock_in            (clock_in),
        .reset_in            (reset_in),
        .instruction_in      (instruction_in),
        .flag_Z_in           (flag_Z_in),
        .flag_N_in           (flag_N_in),
        .program_address_out (program_address_out),
        .operand_out         (operand_out),
        .alu_op_out          (alu_op_out),
        .sel_A_out           (sel_A_out),
        .sel_B_out           (sel_B_out),
        .acc_wr_out          (acc_wr_out),
        .acc_reset_out       (acc_reset_out),
        .status_wr_out       (status_wr_out),
        .status_reset_out    (status_reset_out),
        .data_memory_wr_out  (data_memory_wr_out),
        .halted_out          (halted_out)
    );

    always #5 clock_in = ~clock_in;

    // Observation vector: {pc, operand, alu_op, sel_A, sel_B, acc_wr, acc_reset, status_wr, status_reset, dmem_wr, halted}
    localparam logic [31:0] M_PC   = 32'hFFE0_0000;
    localparam logic [31:0] M_OPD  = 32'h001F_FC00;
    localparam logic [31:0] M_CTL  = 32'h0000_03FE;
    localparam logic [31:0] B_ACCW = 32'h0000_0020;
    localparam logic [31:0] B_SW   = 32'h0000_0008;
    localparam logic [31:0] B_RST  = 32'h0000_0014;
    localparam logic [31:0] B_DMW  = 32'h0000_0002;
    localparam logic [31:0] B_HLT  = 32'h0000_0001;

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
    } probe_t;

    logic [31:0] sb_q [$];
    probe_t      dq [$];
    int          errors = 0;
    int          checks = 0;
    bit          done = 1'b0;

    // Reference model: instruction-level machine (phase 0 fetch, 1 execute, 2 halted)
    int          m_pc = 0;
    logic [15:0] m_ir = 16'h0;
    int          m_phase = 0;

    function automatic logic [31:0] pc_field(input int pc);
        logic [31:0] v;
        v = 32'(pc % 2048) << 21;
        return v;
    endfunction

    function automatic logic [15:0] ins(input int op, input int opd);
        return {5'(op), 11'(opd)};
    endfunction

    function automatic bit branch_taken(input int op, input bit z, input bit n);
        case (op)
            8:  return z;
            9:  return !z;
            10: return !z && !n;
            11: return !n;
            12: return n;
            13: return n || z;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_vec(input bit rst);
        bit       alu, selb, accw, sw, dmw;
        bit [1:0] sela;
        int       op;
        alu = 0; selb = 0; accw = 0; sw = 0; dmw = 0; sela = 2'b00;
        op = int'(m_ir[15:11]);
        if (m_phase == 1) begin
            case (op)
                1: dmw = 1;
                2: begin sela = 2'b01; accw = 1; end
                3: begin sela = 2'b10; accw = 1; end
                4: accw = 1;
                5: begin selb = 1; accw = 1; end
                6: begin alu = 1; accw = 1; sw = 1; end
                7: begin alu = 1; selb = 1; accw = 1; sw = 1; end
                default: ;
            endcase
        end
        return {11'(m_pc), m_ir[10:0], alu, sela, selb, accw, rst, sw, rst, dmw, (m_phase == 2)};
    endfunction

    task automatic model_step(input bit rst, input bit z, input bit n);
        int op;
        if (rst) begin
            m_pc = 0; m_ir = 16'h0; m_phase = 0;
        end else if (m_phase == 0) begin
            m_ir = mem[m_pc];
            m_phase = 1;
        end else if (m_phase == 1) begin
            op = int'(m_ir[15:11]);
            if (op == 0) begin
                m_phase = 2;
            end else begin
                m_phase = 0;
                if (branch_taken(op, z, n)) m_pc = int'(m_ir[10:0]);
                else m_pc = (m_pc + 1) % 2048;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit z, input bit n, input string nm = "",
                       input logic [31:0] dexp = 32'h0, input logic [31:0] dmask = 32'h0);
        probe_t p;
        reset_in  = rst;
        flag_Z_in = z;
        flag_N_in = n;
        sb_q.push_back(model_vec(rst));
        if (nm != "") begin
            p.name = nm; p.exp = dexp & dmask; p.mask = dmask;
            dq.push_back(p);
        end
        @(posedge clock_in);
        #1;
        model_step(rst, z, n);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 2048; i++) mem[i] = ins(31, i);
    endtask

    task automatic branch_case(input string nm, input int op, input bit z, input bit n, input int exp_pc);
        fill_nop();
        mem[0] = ins(op, 11'h040);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, z, n);
        cyc(0, 0, 0, nm, pc_field(exp_pc), M_PC);
    endtask

    function automatic logic [31:0] dut_vec();
        return {program_address_out, operand_out, alu_op_out, sel_A_out, sel_B_out, acc_wr_out,
                acc_reset_out, status_wr_out, status_reset_out, data_memory_wr_out, halted_out};
    endfunction

    // Monitor: pops scoreboard and directed probes each cycle, owns the summary
    initial begin
        logic [31:0] a, e;
        probe_t      d;
        forever begin
            @(negedge clock_in);
            a = dut_vec();
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, a, e);
                end
            end
            if (dq.size() > 0) begin
                d = dq.pop_front();
                checks++;
                if ((a & d.mask) !== d.exp) begin
                    errors++;
                    $display("FAIL %s t=%0t actual=%h required=%h (mask %h)", d.name, $time, a & d.mask, d.exp, d.mask);
                end
            end
            if (done && sb_q.size() == 0 && dq.size() == 0) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int op;
        fill_nop();
        @(posedge clock_in);
        #1;

        // Reset then LDI 5; ADDI 3; STO 7; HLT
        mem[0] = ins(3, 5);
        mem[1] = ins(5, 3);
        mem[2] = ins(1, 7);
        mem[3] = ins(0, 0);
        cyc(1, 0, 0, "reset_outs", B_RST, 32'h0000_03FF);
        cyc(1, 0, 0, "reset_pc", pc_field(0) | B_RST, M_PC | 32'h0000_03FF);
        cyc(0, 0, 0, "post_reset", pc_field(0), M_PC | B_RST | B_HLT);
        cyc(0, 0, 0, "ldi_acc_wr", B_ACCW, B_ACCW);
        cyc(0, 0, 0, "fetch_no_wr", 32'h0, B_ACCW | B_DMW);
        cyc(0, 0, 0, "addi_acc_wr", B_ACCW | 32'h40, B_ACCW | 32'h40);
        cyc(0, 0, 0);
        cyc(0, 0, 0, "sto_wr", (32'd7 << 10) | B_DMW, M_OPD | B_DMW | B_ACCW);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0, "halted_pc", pc_field(3) | B_HLT, M_PC | B_HLT | M_CTL);
        cyc(0, 1, 1, "halt_frozen", pc_field(3) | B_HLT, M_PC | B_HLT | M_CTL);

        // SUBI then BEQ 0x20, with Z set and clear
        for (int k = 0; k < 2; k++) begin
            fill_nop();
            mem[0] = ins(7, 1);
            mem[1] = ins(8, 11'h020);
            cyc(1, 0, 0);
            cyc(0, 0, 0);
            cyc(0, 0, 0, "subi_status_wr", B_SW | B_ACCW, B_SW | B_ACCW);
            cyc(0, 0, 0, "fetch_no_sw", 32'h0, B_SW);
            cyc(0, (k == 0), 0);
            cyc(0, 0, 0, "beq_pc", pc_field((k == 0) ? 32 : 2), M_PC);
        end

        // BGT / BLE over all flag combinations
        branch_case("bgt_z0n0", 10, 0, 0, 64);
        branch_case("bgt_z0n1", 10, 0, 1, 1);
        branch_case("bgt_z1n0", 10, 1, 0, 1);
        branch_case("bgt_z1n1", 10, 1, 1, 1);
        branch_case("ble_z0n0", 13, 0, 0, 1);
        branch_case("ble_z0n1", 13, 0, 1, 64);
        branch_case("ble_z1n0", 13, 1, 0, 64);
        branch_case("ble_z1n1", 13, 1, 1, 64);
        branch_case("bne_z1", 9, 1, 0, 1);
        branch_case("blt_n1", 12, 0, 1, 64);

        // JMP 0x7FF then NOP wraps PC
        fill_nop();
        mem[0] = ins(14, 11'h7FF);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0, "jmp_pc", pc_field(2047), M_PC);
        cyc(0, 0, 0);
        cyc(0, 0, 0, "wrap_pc", pc_field(0), M_PC);

        // Undefined opcode behaves as NOP
        fill_nop();
        mem[0] = ins(31, 11'h123);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 1, "undef_no_strobe", 32'h0, M_CTL);
        cyc(0, 0, 0, "undef_pc", pc_field(1), M_PC | B_HLT);

        // Reset during EXECUTE of ADD
        fill_nop();
        mem[0] = ins(4, 9);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0, "reset_mid_exec", pc_field(0), M_PC | B_ACCW | B_HLT);
        cyc(0, 0, 0, "refetch_exec", B_ACCW, B_ACCW);

        // Randomized programs, flags and occasional resets
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 2048; i++) begin
                op = int'($urandom_range(0, 31));
                if (op == 0 && $urandom_range(0, 9) != 0) op = 1;
                mem[i] = ins(op, int'($urandom_range(0, 2047)));
            end
            cyc(1, 0, 0);
            for (int c = 0; c < 1000; c++)
                cyc($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom));
        end

        done = 1'b1;
    end

endmodule
